// File: rtl/tpu_pkg.sv
// Shared TPU definitions: UB geometry, requester indices and arbiter state encoding.
package tpu_pkg;

  localparam int ADDR_W  = 13;
  localparam int NUM_REQ = 3;

  localparam logic [1:0] REQ_WEIGHT = 2'd0;
  localparam logic [1:0] REQ_INPUT  = 2'd1;
  localparam logic [1:0] REQ_STORE  = 2'd2;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } ub_arb_state_t;

  // (idx + step) mod 3, for idx in 0..2 and step in 0..3
  function automatic logic [1:0] rr_step(input logic [1:0] idx, input logic [1:0] step);
    logic [2:0] sum;
    sum = {1'b0, idx} + {1'b0, step};
    if (sum >= 3'd3) begin
      sum = sum - 3'd3;
    end
    return sum[1:0];
  endfunction

  function automatic logic [2:0] req_onehot(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin pick: the search starts one past the last granted requester.
module rr_arbiter3 (
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] winner,
  output logic       any_valid
);
  import tpu_pkg::*;

  logic [1:0] cand [NUM_REQ];
  logic [2:0] hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      assign cand[gi] = rr_step(ptr, 2'(gi + 1));
      assign hit[gi]  = req[cand[gi]];
    end
  endgenerate

  // Earliest candidate in scan order wins
  always_comb begin
    winner = cand[2];
    if (hit[1]) begin
      winner = cand[1];
    end
    if (hit[0]) begin
      winner = cand[0];
    end
  end

  assign any_valid = |req;

endmodule

// File: rtl/ub_port_arbiter.sv
// Unified-buffer port arbiter: round-robin burst ownership of the single UB port
// for weight fetch, input fetch (reads) and accumulator store (writes).
module ub_port_arbiter #(
  parameter int ADDR_W = tpu_pkg::ADDR_W,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            req_valid,
  input  logic [3*ADDR_W-1:0]   req_addr,
  input  logic [3*LEN_W-1:0]    req_len,
  output logic [2:0]            req_ready,
  output logic [2:0]            rd_valid,
  output logic [DATA_W-1:0]     rd_data,
  input  logic [DATA_W-1:0]     wr_data,
  output logic                  wr_pop,
  output logic [2:0]            done,
  output logic                  busy,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);
  import tpu_pkg::*;

  ub_arb_state_t     state_reg;
  logic [1:0]        owner_reg;
  logic [1:0]        ptr_reg;
  logic [ADDR_W-1:0] base_reg;
  logic [LEN_W-1:0]  last_beat_reg;
  logic [LEN_W-1:0]  beat_reg;
  logic [2:0]        req_ready_reg;
  logic [2:0]        rd_valid_reg;
  logic [2:0]        done_reg;

  logic [ADDR_W-1:0] addr_slice [NUM_REQ];
  logic [LEN_W-1:0]  len_slice  [NUM_REQ];
  logic [1:0]        winner;
  logic              any_valid;
  logic              last_beat;
  logic              in_burst;
  logic [2:0]        rd_valid_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign addr_slice[gi] = req_addr[gi*ADDR_W +: ADDR_W];
      assign len_slice[gi]  = req_len[gi*LEN_W +: LEN_W];
    end
  endgenerate

  rr_arbiter3 u_rr (
    .req       (req_valid),
    .ptr       (ptr_reg),
    .winner    (winner),
    .any_valid (any_valid)
  );

  assign in_burst  = (state_reg == BURST);
  assign last_beat = (beat_reg == last_beat_reg);

  always_comb begin
    rd_valid_next = 3'b000;
    if (in_burst && (owner_reg != REQ_STORE)) begin
      rd_valid_next = req_onehot(owner_reg);
    end
  end

  // len-1 in LEN_W bits makes the 0 encoding land on the full 2**LEN_W beat count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      owner_reg     <= REQ_WEIGHT;
      ptr_reg       <= REQ_STORE;
      base_reg      <= '0;
      last_beat_reg <= '0;
      beat_reg      <= '0;
      req_ready_reg <= 3'b000;
      rd_valid_reg  <= 3'b000;
      done_reg      <= 3'b000;
    end else begin
      req_ready_reg <= 3'b000;
      done_reg      <= 3'b000;
      rd_valid_reg  <= rd_valid_next;
      case (state_reg)
        IDLE: begin
          if (any_valid) begin
            owner_reg     <= winner;
            base_reg      <= addr_slice[winner];
            last_beat_reg <= len_slice[winner] - LEN_W'(1);
            beat_reg      <= '0;
            req_ready_reg <= req_onehot(winner);
            state_reg     <= BURST;
          end
        end
        BURST: begin
          if (last_beat) begin
            ptr_reg   <= owner_reg;
            done_reg  <= req_onehot(owner_reg);
            state_reg <= IDLE;
          end else begin
            beat_reg <= beat_reg + LEN_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy      = in_burst;
  assign mem_en    = in_burst;
  assign mem_we    = in_burst && (owner_reg == REQ_STORE);
  assign mem_addr  = in_burst ? (base_reg + ADDR_W'(beat_reg)) : '0;
  assign mem_wdata = wr_data;
  assign wr_pop    = mem_en & mem_we;

  assign req_ready = req_ready_reg;
  assign rd_valid  = rd_valid_reg;
  assign rd_data   = mem_rdata;
  assign done      = done_reg;

endmodule

// File: tb/tb_ub_port_arbiter.sv
// Scoreboard bench for ub_port_arbiter: stimulus queues expected events, a negedge monitor checks them.
module tb_ub_port_arbiter;

  localparam int AW = 13;
  localparam int DW = 16;
  localparam int LW = 4;

  typedef struct {
    int          cyc;
    int          k;
    logic        we;
    logic [12:0] addr;
    logic [15:0] data;
  } ev_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [2:0]    req_valid = '0;
  logic [38:0]   req_addr = '0;
  logic [11:0]   req_len = '0;
  logic [2:0]    req_ready;
  logic [2:0]    rd_valid;
  logic [15:0]   rd_data;
  logic [15:0]   wr_data;
  logic          wr_pop;
  logic [2:0]    done;
  logic          busy;
  logic          mem_en;
  logic          mem_we;
  logic [12:0]   mem_addr;
  logic [15:0]   mem_wdata;
  logic [15:0]   mem_rdata = '0;

  int cyc = 0;
  int wcnt = 0;
  int exp_wcnt = 0;
  int pop_cnt = 0;
  int vectors = 0;
  int fails = 0;

  ev_t grant_q[$];
  ev_t beat_q[$];
  ev_t rd_q[$];
  ev_t done_q[$];
  ev_t e;

  ub_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .req_ready (req_ready),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .wr_data   (wr_data),
    .wr_pop    (wr_pop),
    .done      (done),
    .busy      (busy),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rd_pat(input logic [12:0] a);
    return {3'b000, a} ^ 16'hA5A5;
  endfunction

  // UB model with one-cycle read latency; store requester advances on wr_pop
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_en && !mem_we) mem_rdata <= rd_pat(mem_addr);
    if (wr_pop) wcnt <= wcnt + 1;
  end
  assign wr_data = 16'hA000 + 16'(wcnt);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop and compare whenever the DUT presents an event
  always @(negedge clk) begin
    if (reset_n) begin
      if (wr_pop) pop_cnt++;
      if (mem_en) begin
        if (beat_q.size() == 0) check("unexpected_beat", 32'(mem_addr), 32'hFFFF_FFFF);
        else begin
          e = beat_q.pop_front();
          check("beat_cycle", 32'(cyc), 32'(e.cyc));
          check("mem_addr", 32'(mem_addr), 32'(e.addr));
          check("mem_we", 32'(mem_we), 32'(e.we));
          check("wr_pop", 32'(wr_pop), 32'(e.we));
          check("busy", 32'(busy), 32'd1);
          if (e.we) check("mem_wdata", 32'(mem_wdata), 32'(e.data));
        end
      end
      if (|req_ready) begin
        if (grant_q.size() == 0) check("unexpected_grant", 32'(req_ready), 32'd0);
        else begin
          e = grant_q.pop_front();
          check("req_ready", 32'(req_ready), 32'(3'b001 << e.k));
          check("grant_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      if (|rd_valid) begin
        if (rd_q.size() == 0) check("unexpected_rd_valid", 32'(rd_valid), 32'd0);
        else begin
          e = rd_q.pop_front();
          check("rd_valid", 32'(rd_valid), 32'(3'b001 << e.k));
          check("rd_cycle", 32'(cyc), 32'(e.cyc));
          check("rd_data", 32'(rd_data), 32'(e.data));
        end
      end
      if (|done) begin
        if (done_q.size() == 0) check("unexpected_done", 32'(done), 32'd0);
        else begin
          e = done_q.pop_front();
          check("done", 32'(done), 32'(3'b001 << e.k));
          check("done_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [12:0] addr, input logic [3:0] len);
    req_valid[k] = 1'b1;
    req_addr[k*AW +: AW] = addr;
    req_len[k*LW +: LW] = len;
  endtask

  task automatic push_burst(input int k, input logic [12:0] addr, input logic [3:0] len, input int fb);
    int n;
    logic [12:0] a;
    n = (len == 4'd0) ? 16 : int'(len);
    grant_q.push_back('{fb, k, 1'b0, 13'd0, 16'd0});
    for (int i = 0; i < n; i++) begin
      a = addr + 13'(i);
      if (k == 2) begin
        beat_q.push_back('{fb + i, k, 1'b1, a, 16'hA000 + 16'(exp_wcnt)});
        exp_wcnt++;
      end else begin
        beat_q.push_back('{fb + i, k, 1'b0, a, 16'd0});
        rd_q.push_back('{fb + i + 1, k, 1'b0, a, rd_pat(a)});
      end
    end
    done_q.push_back('{fb + n, k, 1'b0, 13'd0, 16'd0});
    $display("burst: requester %0d addr %0h beats %0d first beat cycle %0d", k, addr, n, fb);
  endtask

  task automatic drain();
    int n = 0;
    while ((grant_q.size() + beat_q.size() + rd_q.size() + done_q.size()) != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("drain_pending", 32'(grant_q.size() + beat_q.size() + rd_q.size() + done_q.size()), 32'd0);
    grant_q.delete(); beat_q.delete(); rd_q.delete(); done_q.delete();
    #1;
  endtask

  task automatic single_burst(input int k, input logic [12:0] addr, input logic [3:0] len);
    int c;
    c = cyc;
    set_req(k, addr, len);
    push_burst(k, addr, len, c + 1);
    step();
    req_valid[k] = 1'b0;
    drain();
  endtask

  task automatic chk_quiet(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_mem_en"}, 32'(mem_en), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_wr_pop"}, 32'(wr_pop), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int p0;
    @(negedge clk);
    chk_quiet("reset");
    step(); step();
    reset_n = 1'b1;
    step();

    // Round robin from reset with all requesters held: 0,1,2,0
    c = cyc;
    set_req(0, 13'h020, 4'd2);
    set_req(1, 13'h040, 4'd2);
    set_req(2, 13'h060, 4'd2);
    push_burst(0, 13'h020, 4'd2, c + 1);
    push_burst(1, 13'h040, 4'd2, c + 4);
    push_burst(2, 13'h060, 4'd2, c + 7);
    push_burst(0, 13'h020, 4'd2, c + 10);
    repeat (10) step();
    req_valid = 3'b000;
    drain();

    single_burst(0, 13'h010, 4'd4);

    p0 = pop_cnt;
    single_burst(2, 13'h100, 4'd3);
    check("wr_pop_count", 32'(pop_cnt - p0), 32'd3);

    single_burst(1, 13'h1FFE, 4'd4);
    single_burst(0, 13'h0200, 4'd0);

    // Reset in burst cycle 2, then requesters 1 and 2 compete
    c = cyc;
    set_req(1, 13'h300, 4'd4);
    grant_q.push_back('{c + 1, 1, 1'b0, 13'd0, 16'd0});
    beat_q.push_back('{c + 1, 1, 1'b0, 13'h300, 16'd0});
    step();
    req_valid[1] = 1'b0;
    step();
    reset_n = 1'b0;
    set_req(1, 13'h340, 4'd2);
    set_req(2, 13'h380, 4'd1);
    @(negedge clk);
    chk_quiet("abort");
    check("abort_beats_consumed", 32'(beat_q.size()), 32'd0);
    step();
    reset_n = 1'b1;
    c = cyc;
    push_burst(1, 13'h340, 4'd2, c + 1);
    push_burst(2, 13'h380, 4'd1, c + 4);
    step();
    req_valid[1] = 1'b0;
    repeat (3) step();
    req_valid[2] = 1'b0;
    drain();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
